i2c_controller_ebr_drainer: RTL and testbench
=============================================

// Module: i2c_controller_ebr_drainer
// PURPOSE
//   I2C controller (initiator) that streams a block of bytes out of one of two EBRs to an I2C peripheral.
//   This is the transmit-side counterpart of the EBR-filling I2C peripheral.
//   On start it issues START, 7-bit address + W, then byte_count EBR bytes from address 0 upward, then STOP.
//   It sits between the EBR pair (read port) and the open-drain SCL/SDA pads. Single-master bus; no arbitration.
// PARAMETERS
//   CLK_DIV     30  clocks per SCL quarter-bit (12 MHz / (4*30) = 100 kHz); must be >= 2
//   EBR_ADDR_W  9   EBR address width (512 bytes per EBR)
// PORTS
//   clock         in   1             system clock; all state on rising edge
//   reset_n       in   1             asynchronous, active-low reset
//   i_scl         in   1             SCL pad sense
//   i_sda         in   1             SDA pad sense
//   o_scl         out  1             SCL drive: 0 = pull low, 1 = release
//   o_sda         out  1             SDA drive: 0 = pull low, 1 = release
//   start         in   1             1-cycle pulse; begins a transfer when busy=0
//   src_select    in   1             EBR to drain (0/1); sampled with start
//   target_addr   in   7             peripheral address; sampled with start
//   byte_count    in   EBR_ADDR_W+1  bytes to send; 0 = address-only probe; sampled with start
//   ebr_select    out  1             EBR being read (latched src_select)
//   ebr_rden      out  1             EBR read enable; data valid on ebr_data_in next cycle
//   ebr_addr      out  EBR_ADDR_W    EBR read address
//   ebr_data_in   in   8             EBR read data
//   busy          out  1             1 from cycle after accepted start until done pulses
//   done          out  1             1-cycle pulse at end of transfer (success or NACK)
//   nack_error    out  1             set with done if any NACK was seen; cleared on next accepted start
//   bytes_sent    out  EBR_ADDR_W+1  data bytes ACKed in current/last transfer
// BEHAVIOUR
//   Reset: o_scl=o_sda=1, ebr_rden=0, ebr_addr=0, ebr_select=0, busy=done=nack_error=0, bytes_sent=0, state IDLE.
//   Reset mid-transfer releases both lines immediately. The bus may be left mid-byte; this is accepted.
//   Quarter tick: counter 0..CLK_DIV-1, one tick per wrap. Counter runs only while busy.
//   Clock stretch: in any quarter where o_scl=1, the counter holds until i_scl reads 1.
//   start while busy: ignored, including its sampled inputs.
//   States: IDLE -> START -> ADDR -> ACK -> (FETCH -> DATA -> ACK)* -> STOP -> IDLE.
//   START: Q0 SDA low with SCL released; Q1 SCL low.
//   Bit (ADDR/DATA, MSB first, 8 bits; ADDR byte = {target_addr,1'b0}):
//     Q0 SCL low, set SDA; Q1 SCL low; Q2 release SCL; Q3 SCL high.
//   ACK: same 4 quarters with SDA released. i_sda is sampled at the end of Q3; 0 = ACK, 1 = NACK.
//   After ACK: on NACK -> STOP with nack_error=1.
//     On ACK, if sent < byte_count -> FETCH (bytes_sent increments if data ACK); else -> STOP.
//   FETCH, 2 clocks, SCL held low:
//     cycle 1: ebr_rden=1, ebr_addr=current index.
//     cycle 2: load ebr_data_in into shift register; index increments.
//   ebr_rden is high only in FETCH cycle 1. The index starts at 0 and never wraps: byte_count <= 2^EBR_ADDR_W.
//   STOP: Q0 SCL low, SDA low; Q1 release SCL; Q2 (SCL high) release SDA; Q3 bus-free hold.
//     Then done=1 for 1 cycle, busy=0.
//   byte_count=0: START, ADDR, ACK, STOP; no EBR reads.
//   o_sda changes only while SCL is driven low, except in START and STOP.
// TESTING
//   1. addr 0x42, count 3, EBR0={A5,01,FF}, ACKing model -> bus bytes 84,A5,01,FF; done; nack_error=0; bytes_sent=3.
//   2. addr 0x42, model NACKs address -> 84 then STOP; no ebr_rden pulses; nack_error=1; bytes_sent=0.
//   3. count 0, src_select=1 -> START, address byte, STOP only; ebr_rden never high; done pulses once.
//   4. Model stretches SCL 500 clocks on bit 3 of byte 2 -> data unchanged; SCL-high time >= CLK_DIV after release.
//   5. count 4, model NACKs byte 2 -> STOP after byte 2; bytes_sent=1; nack_error=1; EBR address 2 never read.
//   6. reset_n low mid-DATA -> o_scl=o_sda=1 same cycle; start pulsed while busy earlier was ignored.

Source files
------------

// File: rtl/i2c_controller_ebr_drainer.sv
// I2C initiator: START, {target_addr,W}, byte_count EBR bytes from address 0 upward, STOP.
// Each bit is four quarters of CLK_DIV clocks; a peripheral holding SCL low freezes the quarter counter.
module i2c_controller_ebr_drainer #(
    parameter int CLK_DIV    = 30,
    parameter int EBR_ADDR_W = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_scl,
    output logic                  o_sda,
    input  logic                  start,
    input  logic                  src_select,
    input  logic [6:0]            target_addr,
    input  logic [EBR_ADDR_W:0]   byte_count,
    output logic                  ebr_select,
    output logic                  ebr_rden,
    output logic [EBR_ADDR_W-1:0] ebr_addr,
    input  logic [7:0]            ebr_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  nack_error,
    output logic [EBR_ADDR_W:0]   bytes_sent
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK, S_FETCH, S_DATA, S_STOP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         qcnt;
    logic [1:0]            q;
    logic [2:0]            bitcnt;
    logic [7:0]            shreg;
    logic                  fetch_ph;
    logic                  in_data;
    logic [EBR_ADDR_W:0]   idx;
    logic [EBR_ADDR_W:0]   count_r;
    logic                  scl_d, sda_d;
    logic                  hold, qrun, tick, bit_end;

    assign hold    = o_scl & ~i_scl;
    assign qrun    = (state != S_IDLE) && (state != S_FETCH);
    assign tick    = qrun && !hold && (qcnt == CW'(CLK_DIV - 1));
    assign bit_end = tick && (q == 2'd3);
    assign busy    = (state != S_IDLE);
    assign ebr_addr = idx[EBR_ADDR_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        scl_d    = 1'b1;
        sda_d    = 1'b1;
        ebr_rden = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_START;
            end
            S_START: begin
                scl_d = (q == 2'd0);
                sda_d = 1'b0;
                if (tick && q == 2'd1) state_n = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                scl_d = q[1];
                sda_d = shreg[7];
                if (bit_end && bitcnt == 3'd7) state_n = S_ACK;
            end
            S_ACK: begin
                scl_d = q[1];
                if (bit_end) begin
                    if (!i_sda && idx < count_r) state_n = S_FETCH;
                    else                         state_n = S_STOP;
                end
            end
            S_FETCH: begin
                scl_d    = 1'b0;
                ebr_rden = !fetch_ph;
                if (fetch_ph) state_n = S_DATA;
            end
            S_STOP: begin
                scl_d = (q != 2'd0);
                sda_d = q[1];
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_scl      <= 1'b1;
            o_sda      <= 1'b1;
            done       <= 1'b0;
            fetch_ph   <= 1'b0;
            qcnt       <= '0;
            q          <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            in_data    <= 1'b0;
            idx        <= '0;
            count_r    <= '0;
            ebr_select <= 1'b0;
            nack_error <= 1'b0;
            bytes_sent <= '0;
        end else begin
            o_scl <= scl_d;
            // SDA may only move while SCL is already low, or while SCL stays high (START/STOP edges)
            if (!o_scl || scl_d) o_sda <= sda_d;
            done     <= (state == S_STOP) && (state_n == S_IDLE);
            fetch_ph <= (state == S_FETCH) && !fetch_ph;

            if (!qrun)      qcnt <= '0;
            else if (!hold) qcnt <= tick ? '0 : qcnt + 1'b1;

            if (state != state_n) q <= '0;
            else if (tick)        q <= q + 2'd1;

            if (state == S_IDLE && start) begin
                ebr_select <= src_select;
                count_r    <= byte_count;
                shreg      <= {target_addr, 1'b0};
                bitcnt     <= '0;
                idx        <= '0;
                in_data    <= 1'b0;
                nack_error <= 1'b0;
                bytes_sent <= '0;
            end

            if ((state == S_ADDR || state == S_DATA) && bit_end) begin
                shreg  <= {shreg[6:0], 1'b0};
                bitcnt <= bitcnt + 3'd1;
            end

            if (state == S_FETCH && fetch_ph) begin
                shreg   <= ebr_data_in;
                idx     <= idx + 1'b1;
                in_data <= 1'b1;
            end

            if (state == S_ACK && bit_end) begin
                if (i_sda)        nack_error <= 1'b1;
                else if (in_data) bytes_sent <= bytes_sent + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_controller_ebr_drainer.sv
// Bench for i2c_controller_ebr_drainer: bus-level peripheral/monitor, EBR model, vector table and random transfers.
module tb_i2c_controller_ebr_drainer;
    localparam int CLK_DIV = 4;
    localparam int AW      = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          o_scl, o_sda;
    logic          start, src_select;
    logic [6:0]    target_addr;
    logic [AW:0]   byte_count;
    logic          ebr_select, ebr_rden;
    logic [AW-1:0] ebr_addr;
    logic [7:0]    ebr_data_in = 8'h00;
    logic          busy, done, nack_error;
    logic [AW:0]   bytes_sent;
    logic          slave_scl = 1'b1, slave_sda = 1'b1;
    logic          scl_bus, sda_bus;

    assign scl_bus = o_scl & slave_scl;
    assign sda_bus = o_sda & slave_sda;

    always #5 clock = ~clock;

    i2c_controller_ebr_drainer #(.CLK_DIV(CLK_DIV), .EBR_ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n), .i_scl(scl_bus), .i_sda(sda_bus),
        .o_scl(o_scl), .o_sda(o_sda), .start(start), .src_select(src_select),
        .target_addr(target_addr), .byte_count(byte_count), .ebr_select(ebr_select),
        .ebr_rden(ebr_rden), .ebr_addr(ebr_addr), .ebr_data_in(ebr_data_in),
        .busy(busy), .done(done), .nack_error(nack_error), .bytes_sent(bytes_sent)
    );

    logic [7:0] mem [2][512];

    always @(posedge clock) begin
        if (ebr_rden) ebr_data_in <= mem[ebr_select][ebr_addr];
    end

    // Peripheral + bus monitor state (written only by the monitor process)
    int         clr_req = 0, clr_seen = 0;
    int         cfg_nack = -1, cfg_sbyte = -1;
    int         bitn = 0, byte_idx = 0, starts = 0, stops = 0;
    int         done_cnt = 0, rden_cnt = 0, rd_bad = 0;
    int         stretch_left = 0, hi_len = 0, hi_meas = -1;
    bit         acking = 0, stretched = 0, measuring = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] cap[$];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clock) begin
        logic cs, cd;
        cs = scl_bus;
        cd = sda_bus;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            cap.delete();
            bitn = 0; byte_idx = 0; starts = 0; stops = 0; done_cnt = 0;
            rden_cnt = 0; rd_bad = 0; stretch_left = 0; hi_meas = -1;
            acking = 0; stretched = 0; measuring = 0;
            slave_scl = 1'b1; slave_sda = 1'b1;
        end else begin
            if (ebr_rden) begin
                if (int'(ebr_addr) != rden_cnt) rd_bad++;
                rden_cnt++;
            end
            if (done) done_cnt++;
            if (measuring) begin
                if (cs) hi_len++;
                else begin hi_meas = hi_len; measuring = 0; end
            end
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) begin slave_scl = 1'b1; measuring = 1; hi_len = 0; end
            end
            if (prev_scl && cs && prev_sda && !cd) begin
                starts++; bitn = 0; acking = 0;
            end else if (prev_scl && cs && !prev_sda && cd) begin
                stops++;
            end else if (!prev_scl && cs) begin
                if (bitn < 8) begin sh = {sh[6:0], cd}; bitn++; end
            end else if (prev_scl && !cs) begin
                if (acking) begin
                    slave_sda = 1'b1; acking = 0; bitn = 0; byte_idx++;
                end else if (bitn == 8) begin
                    cap.push_back(sh);
                    acking = 1;
                    slave_sda = (byte_idx == cfg_nack);
                end
                if (!stretched && !acking && byte_idx == cfg_sbyte && bitn == 3) begin
                    stretched = 1; stretch_left = 500; slave_scl = 1'b0;
                end
            end
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Transfer outcome from the protocol rules: bus byte nk (0 = address) is the one NACKed
    function automatic void model(input int cnt, input int nk, output int sent, output bit nack, output int nbytes);
        if (nk < 0 || nk > cnt) begin
            sent = cnt; nack = 1'b0; nbytes = cnt + 1;
        end else begin
            sent = (nk == 0) ? 0 : nk - 1; nack = 1'b1; nbytes = nk + 1;
        end
    endfunction

    task automatic clear_monitor();
        @(negedge clock);
        clr_req++;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic run_xfer(input bit src, input logic [6:0] addr, input int cnt, input int nk,
                            input int sbyte, input int exp_sent, input bit exp_nack);
        int         msent, nbytes, budget;
        bit         mnack, got;
        logic [7:0] eb;
        model(cnt, nk, msent, mnack, nbytes);
        cfg_nack  = nk;
        cfg_sbyte = sbyte;
        clear_monitor();
        src_select = src; target_addr = addr; byte_count = cnt[AW:0]; start = 1'b1;
        @(negedge clock);
        start = 1'b0; src_select = ~src; target_addr = ~addr; byte_count = '1;
        check("busy_after_start", busy, 1);
        budget = (cnt + 2) * 40 * CLK_DIV + 1000;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        check("nack_error", nack_error, exp_nack);
        check("bytes_sent", bytes_sent, exp_sent);
        check("ebr_select", ebr_select, src);
        repeat (20) @(negedge clock);
        check("done_once", done_cnt, 1);
        check("start_cond", starts, 1);
        check("stop_cond", stops, 1);
        check("bus_bytes", cap.size(), nbytes);
        for (int i = 0; i < nbytes && i < cap.size(); i++) begin
            eb = (i == 0) ? {addr, 1'b0} : mem[src][i-1];
            check($sformatf("bus_byte%0d", i), cap[i], eb);
        end
        check("rden_pulses", rden_cnt, nbytes - 1);
        check("rd_order", rd_bad, 0);
        if (sbyte >= 0) check("stretch_high_ge_div", (hi_meas >= CLK_DIV), 1);
    endtask

    typedef struct {
        bit       src;
        bit [6:0] addr;
        int       cnt;
        int       nk;
        int       sbyte;
        int       exp_sent;
        bit       exp_nack;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  rs, rn, rb, cnt, nk;
        bit  rk, flag;
        vecs[0] = '{1'b0, 7'h42, 3, -1, -1, 3, 1'b0};
        vecs[1] = '{1'b0, 7'h42, 3,  0, -1, 0, 1'b1};
        vecs[2] = '{1'b1, 7'h42, 0, -1, -1, 0, 1'b0};
        vecs[3] = '{1'b1, 7'h3C, 3, -1,  2, 3, 1'b0};
        vecs[4] = '{1'b0, 7'h42, 4,  2, -1, 1, 1'b1};
        vecs[5] = '{1'b1, 7'h7F, 1,  1, -1, 0, 1'b1};
        vecs[6] = '{1'b0, 7'h00, 5,  5, -1, 4, 1'b1};

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 512; a++) mem[s][a] = 8'($urandom);
        mem[0][0] = 8'hA5; mem[0][1] = 8'h01; mem[0][2] = 8'hFF;

        reset_n = 1'b0; start = 1'b0; src_select = 1'b0; target_addr = '0; byte_count = '0;
        repeat (3) @(negedge clock);
        check("rst_outputs", {o_scl, o_sda, ebr_rden, ebr_select, busy, done, nack_error},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_ebr_addr", ebr_addr, 0);
        check("rst_bytes_sent", bytes_sent, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        for (int v = 0; v < 7; v++)
            run_xfer(vecs[v].src, vecs[v].addr, vecs[v].cnt, vecs[v].nk, vecs[v].sbyte,
                     vecs[v].exp_sent, vecs[v].exp_nack);

        for (int r = 0; r < 12; r++) begin
            cnt = $urandom_range(0, 5);
            nk  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt) : -1;
            model(cnt, nk, rs, rk, rn);
            rb  = $urandom_range(0, 1);
            run_xfer(rb[0], 7'($urandom), cnt, nk, -1, rs, rk);
        end

        // Reset in the middle of a data byte, after an ignored start request
        cfg_nack = -1; cfg_sbyte = -1;
        clear_monitor();
        src_select = 1'b0; target_addr = 7'h2A; byte_count = 10'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        flag = 0;
        for (int i = 0; i < 5000 && !flag; i++) begin
            @(negedge clock);
            if (rden_cnt >= 1) flag = 1;
        end
        check("mid_first_fetch", flag, 1);
        src_select = 1'b1; target_addr = 7'h11; byte_count = 10'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ignored_start_sel", ebr_select, 0);
        check("ignored_start_busy", busy, 1);
        flag = 0;
        for (int i = 0; i < 5000 && !flag; i++) begin
            @(negedge clock);
            if (byte_idx == 1 && bitn >= 3 && !acking && o_scl == 1'b0) flag = 1;
        end
        check("reached_mid_data", flag, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_scl", o_scl, 1);
        check("rst_mid_sda", o_sda, 1);
        check("rst_mid_busy", busy, 0);
        check("ignored_start_addr", (cap.size() > 0) ? cap[0] : 8'h00, {7'h2A, 1'b0});
        check("ignored_start_starts", starts, 1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        run_xfer(1'b1, 7'h55, 2, -1, -1, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
